// File: rtl/interrupt_controller.sv
// Vectored interrupt controller: edge-captured sources, fixed priority,
// IDLE/REQ/SERVICE handshake with IntAck and EOI.
module interrupt_controller #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             CS_N,
    input  logic             RD_N,
    input  logic             WR_N,
    input  logic [11:0]      Addr,
    input  logic [31:0]      DataIn,
    output logic [31:0]      DataOut,
    input  logic [N_SRC-1:0] IntrIn_N,
    output logic             IRQ,
    input  logic             IntAck,
    output logic [2:0]       Vector
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SVC  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] hist_q;
    logic             irq_q, irq_d;
    logic [2:0]       vec_q, vec_d;

    logic             wr, rd;
    logic             wr_pend, wr_en, wr_eoi;
    logic [N_SRC-1:0] elig, set_ev, vec_oh;
    logic [N_SRC-1:0] w1c_mask, ack_mask;
    logic             any_elig, cur_ok, ack_ok;
    logic [2:0]       sel;
    logic [31:0]      status;
    logic             unused_hi;

    assign unused_hi = ^DataIn[31:N_SRC];

    assign wr      = ~CS_N & ~WR_N;
    assign rd      = ~CS_N & ~RD_N;
    assign wr_pend = wr & (Addr == 12'h000);
    assign wr_en   = wr & (Addr == 12'h100);
    assign wr_eoi  = wr & (Addr == 12'h300);

    assign elig     = pending_q & enable_q;
    assign any_elig = |elig;
    assign vec_oh   = N_SRC'(1) << vec_q;
    assign cur_ok   = |(elig & vec_oh);
    assign ack_ok   = (state_q == S_REQ) & IntAck;

    // Falling edge of an active-low line; history starts high after reset
    assign set_ev   = hist_q & ~IntrIn_N;
    assign w1c_mask = wr_pend ? DataIn[N_SRC-1:0] : '0;
    assign ack_mask = ack_ok ? vec_oh : '0;

    assign pending_d = (pending_q & ~(w1c_mask | ack_mask)) | set_ev;
    assign enable_d  = wr_en ? DataIn[N_SRC-1:0] : enable_q;

    always_comb begin
        sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) sel = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            enable_q  <= '0;
            hist_q    <= '1;
            irq_q     <= 1'b0;
            vec_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            hist_q    <= IntrIn_N;
            irq_q     <= irq_d;
            vec_q     <= vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (any_elig) state_d = S_REQ;
            S_REQ: begin
                if (IntAck)       state_d = S_SVC;
                else if (!cur_ok) state_d = S_IDLE;
            end
            S_SVC: if (wr_eoi) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Vector latches only on the IDLE->REQ arbitration and holds otherwise
    always_comb begin
        irq_d = (state_d == S_REQ);
        vec_d = vec_q;
        if (state_q == S_IDLE && state_d == S_REQ) vec_d = sel;
    end

    assign status = {23'b0, any_elig, 2'b0, state_q, 1'b0, vec_q};

    always_comb begin
        DataOut = '0;
        if (rd) begin
            unique case (Addr)
                12'h000: DataOut = 32'(pending_q);
                12'h100: DataOut = 32'(enable_q);
                12'h200: DataOut = status;
                default: DataOut = '0;
            endcase
        end
    end

    assign IRQ    = irq_q;
    assign Vector = vec_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: capture, priority, handshake,
// masking/withdraw, W1C races and reset during service.
module tb_interrupt_controller;

    logic        clk;
    logic        reset;
    logic        CS_N, RD_N, WR_N;
    logic [11:0] Addr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic [7:0]  IntrIn_N;
    logic        IRQ;
    logic        IntAck;
    logic [2:0]  Vector;

    int total = 0;
    int bad   = 0;

    interrupt_controller #(.N_SRC(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .CS_N    (CS_N),
        .RD_N    (RD_N),
        .WR_N    (WR_N),
        .Addr    (Addr),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .IntrIn_N(IntrIn_N),
        .IRQ     (IRQ),
        .IntAck  (IntAck),
        .Vector  (Vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        CS_N = 1'b0;
        RD_N = 1'b0;
        Addr = a;
        #1;
        d = DataOut;
        CS_N = 1'b1;
        RD_N = 1'b1;
        Addr = '0;
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        CS_N   = 1'b0;
        WR_N   = 1'b0;
        Addr   = a;
        DataIn = d;
        @(negedge clk);
        CS_N   = 1'b1;
        WR_N   = 1'b1;
        Addr   = '0;
        DataIn = '0;
    endtask

    task automatic ack();
        IntAck = 1'b1;
        @(negedge clk);
        IntAck = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        CS_N     = 1'b1;
        RD_N     = 1'b1;
        WR_N     = 1'b1;
        Addr     = '0;
        DataIn   = '0;
        IntrIn_N = 8'hFF;
        IntAck   = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);

        chk("rst_irq", 32'(IRQ), 32'h0);
        chk("rst_vec", 32'(Vector), 32'h0);
        rd_chk("rst_pend", 12'h000, 32'h0);
        rd_chk("rst_en", 12'h100, 32'h0);
        rd_chk("rst_stat", 12'h200, 32'h0);

        // single timer source full handshake
        wr(12'h100, 32'h01);
        rd_chk("t1_en", 12'h100, 32'h01);
        IntrIn_N = 8'hFE;
        step(1);
        rd_chk("t1_pend", 12'h000, 32'h01);
        chk("t1_irq0", 32'(IRQ), 32'h0);
        step(1);
        chk("t1_irq1", 32'(IRQ), 32'h1);
        chk("t1_vec", 32'(Vector), 32'h0);
        rd_chk("t1_stat_req", 12'h200, 32'h110);
        ack();
        chk("t1_irq_ack", 32'(IRQ), 32'h0);
        rd_chk("t1_pend_ack", 12'h000, 32'h0);
        rd_chk("t1_stat_svc", 12'h200, 32'h020);
        rd_chk("t1_eoi_rd", 12'h300, 32'h0);
        wr(12'h300, 32'hDEAD);
        rd_chk("t1_stat_idle", 12'h200, 32'h000);
        IntrIn_N = 8'hFF;
        step(1);

        // simultaneous sources 5 and 2
        wr(12'h100, 32'hFF);
        IntrIn_N = ~8'h24;
        step(1);
        rd_chk("t2_pend", 12'h000, 32'h24);
        step(1);
        chk("t2_irq", 32'(IRQ), 32'h1);
        chk("t2_vec2", 32'(Vector), 32'h2);
        ack();
        rd_chk("t2_stat_svc", 12'h200, 32'h122);
        step(2);
        chk("t2_svc_wait", 32'(IRQ), 32'h0);
        wr(12'h300, 32'h0);
        chk("t2_eoi_irq0", 32'(IRQ), 32'h0);
        step(1);
        chk("t2_irq5", 32'(IRQ), 32'h1);
        chk("t2_vec5", 32'(Vector), 32'h5);
        ack();
        wr(12'h300, 32'h0);
        IntrIn_N = 8'hFF;
        step(1);
        rd_chk("t2_pend_end", 12'h000, 32'h0);

        // masked source stays pending, then enabled; W1C withdraw
        wr(12'h100, 32'h00);
        IntrIn_N = ~8'h08;
        step(1);
        rd_chk("t3_pend", 12'h000, 32'h08);
        step(2);
        chk("t3_masked", 32'(IRQ), 32'h0);
        ack();
        rd_chk("t3_ack_ign", 12'h000, 32'h08);
        wr(12'h100, 32'h08);
        step(1);
        chk("t3_irq", 32'(IRQ), 32'h1);
        chk("t3_vec", 32'(Vector), 32'h3);
        wr(12'h000, 32'h08);
        rd_chk("t3_w1c", 12'h000, 32'h0);
        step(1);
        chk("t3_withdraw", 32'(IRQ), 32'h0);
        rd_chk("t3_stat", 12'h200, 32'h003);
        IntrIn_N = 8'hFF;

        // mask withdraw in REQ; EOI in REQ ignored
        wr(12'h100, 32'hFF);
        IntrIn_N = ~8'h10;
        step(2);
        chk("t4_irq", 32'(IRQ), 32'h1);
        chk("t4_vec", 32'(Vector), 32'h4);
        wr(12'h300, 32'h0);
        step(1);
        rd_chk("t4_eoi_ign", 12'h200, 32'h114);
        wr(12'h100, 32'h00);
        step(1);
        chk("t4_irq0", 32'(IRQ), 32'h0);
        rd_chk("t4_stat", 12'h200, 32'h004);
        rd_chk("t4_pend", 12'h000, 32'h10);
        wr(12'h000, 32'h10);
        IntrIn_N = 8'hFF;
        step(1);

        // set beats W1C on the same edge; held line sets only once
        IntrIn_N = 8'hFE;
        wr(12'h000, 32'h01);
        rd_chk("t5_set_wins", 12'h000, 32'h01);
        wr(12'h000, 32'h01);
        rd_chk("t5_clr", 12'h000, 32'h0);
        step(10);
        rd_chk("t5_held", 12'h000, 32'h0);
        IntrIn_N = 8'hFF;
        step(1);

        // reset during service with line 1 held low
        wr(12'h100, 32'h02);
        IntrIn_N = 8'hFD;
        step(2);
        chk("t6_irq", 32'(IRQ), 32'h1);
        chk("t6_vec", 32'(Vector), 32'h1);
        ack();
        rd_chk("t6_svc", 12'h200, 32'h021);
        reset = 1'b1;
        step(1);
        chk("t6_rst_irq", 32'(IRQ), 32'h0);
        chk("t6_rst_vec", 32'(Vector), 32'h0);
        rd_chk("t6_rst_pend", 12'h000, 32'h0);
        rd_chk("t6_rst_en", 12'h100, 32'h0);
        rd_chk("t6_rst_stat", 12'h200, 32'h0);
        reset = 1'b0;
        step(1);
        rd_chk("t6_pend_set", 12'h000, 32'h02);
        wr(12'h000, 32'h02);
        step(3);
        rd_chk("t6_pend_once", 12'h000, 32'h0);
        chk("t6_irq_end", 32'(IRQ), 32'h0);
        CS_N = 1'b1;
        RD_N = 1'b0;
        Addr = 12'h100;
        #1;
        chk("no_cs_read", DataOut, 32'h0);
        RD_N = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter N_SRC, default 8, number of interrupt sources (1..8); vector fields are 3 bits wide.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 CS_N  input  1  chip select, active-low.
REQ-005 RD_N  input  1  read strobe, active-low.
REQ-006 WR_N  input  1  write strobe, active-low.
REQ-007 Addr  input  12  register offset within the controller's page.
REQ-008 DataIn  input  32  write data.
REQ-009 DataOut  output  32  read data; combinational.
REQ-010 IntrIn_N  input  N_SRC  active-low interrupt lines; bit 0 is the timer (Intr), lower index = higher priority.
REQ-011 IRQ  output  1  registered interrupt request to CPU, active-high.
REQ-012 IntAck  input  1  CPU acknowledge, single-cycle high pulse.
REQ-013 Vector  output  3  registered index of the source currently requested or in service.

Function
REQ-014 Register map: 0x000 Pending (R, write-1-to-clear); 0x100 Enable (R/W, bits [N_SRC-1:0]); 0x200 Status (R-only); 0x300 EOI (W-only, data ignored); writes to other offsets have no effect.
REQ-015 Read: when ~CS_N & ~RD_N, DataOut = selected register zero-extended to 32 bits; 0x300, unmapped offsets, or no read strobe -> 32'h0.
REQ-016 Status layout: [2:0] Vector, [5:4] FSM state (IDLE=0, REQ=1, SERVICE=2), [8] |(Pending & Enable), other bits 0.
REQ-017 Edge detect: per source, a history register holds the previous IntrIn_N sample; history=1 and current=0 at a rising edge sets that Pending bit on that same edge.
REQ-018 A held-low line sets Pending only once; a new set requires the line to return high for at least one cycle.
REQ-019 Pending bit clears on a W1C write with DataIn bit = 1 or on IntAck for the captured vector; a set event in the same cycle wins over either clear.
REQ-020 Enable does not gate Pending capture; masked sources remain pending and become eligible when enabled.
REQ-021 Priority: selected source = lowest index i with Pending[i] & Enable[i].
REQ-022 FSM IDLE: IRQ=0; if any eligible source, capture its index into Vector and go to REQ; IRQ rises at the edge after Pending&Enable first becomes nonzero.
REQ-023 FSM REQ: IRQ=1, Vector held even if a higher-priority source becomes pending; on IntAck -> SERVICE, clear Pending[Vector], IRQ=0 next cycle.
REQ-024 FSM REQ withdraw: if Pending[Vector]&Enable[Vector] becomes 0 without IntAck (masked or W1C), go to IDLE, IRQ=0 next cycle; IntAck in the same cycle takes precedence.
REQ-025 FSM SERVICE: IRQ=0, Vector held, new requests wait; an EOI write (~CS_N & ~WR_N, Addr=0x300) -> IDLE; re-arbitration occurs from IDLE on the following cycle.
REQ-026 IntAck outside REQ, or EOI outside SERVICE, is ignored.
REQ-027 Writes to 0x000 and 0x100 are accepted in every FSM state.

Reset
REQ-028 On reset: Pending=0, Enable=0, Vector=0, IRQ=0, FSM=IDLE, all history bits=1, so a line already low at reset release produces one Pending set on the first active cycle.
REQ-029 Reset asserted mid-request or mid-service overrides all other events and returns to the REQ-028 state on that edge.

Verification
REQ-030 Enable=0x01, drive IntrIn_N[0] high->low -> Pending=0x01 next edge, IRQ=1 and Vector=0 one edge later; IntAck -> IRQ=0, Pending=0x00, Status[5:4]=2; EOI -> Status[5:4]=0.
REQ-031 Enable=0xFF, lines 5 and 2 fall on the same cycle -> Vector=2; after IntAck+EOI, Vector=5 and IRQ=1 on the second edge after EOI.
REQ-032 Enable=0x00, line 3 falls -> Pending=0x08, IRQ stays 0; write Enable=0x08 -> IRQ=1, Vector=3.
REQ-033 In REQ with Vector=4, write Enable=0x00 -> IRQ=0 next edge, FSM=IDLE, Pending still 0x10.
REQ-034 W1C 0x01 on the same edge line 0 falls -> Pending[0]=1; line 0 held low for 10 cycles after clear -> Pending[0] stays 0.
REQ-035 Reset during SERVICE with line 1 held low -> all registers 0, IRQ=0; after release, Pending=0x02 once.
